// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline hazard controller and the datapath: hazard
// observations flow into the controller, register strobes and status flow out.
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    // Hazard observations from the datapath
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [REG_W-1:0] ex_rt;
    logic             branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             wb_halt;

    // Pipeline-register strobes and status back to the datapath
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_flush;
    logic             halted;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               branch_taken, mem_req, mem_ready, wb_halt,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_flush, halted, mem_timeout, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt,
               branch_taken, mem_req, mem_ready, wb_halt,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_flush, halted, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: per-stage enables and flushes for
// load-use, taken branch, data-memory wait and halt, plus stall/timeout status.
module pipe_hazard_ctrl #(
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WAIT_W-1:0]  wait_cnt_q;
    logic               mem_timeout_q;
    logic [CNT_W-1:0]   stall_cnt_q;

    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic [REG_W-1:0]   ex_rt;
    logic               mem_stall;
    logic               load_use;
    logic               wait_tick;
    logic               timeout_hit;

    logic               pc_en_c;
    logic               ifid_en_c;
    logic               ifid_flush_c;
    logic               idex_en_c;
    logic               idex_flush_c;
    logic               exmem_en_c;
    logic               memwb_flush_c;
    logic               halted_c;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [WAIT_W-1:0] sat_inc_wait(input logic [WAIT_W-1:0] v);
        return (v == WAIT_W'(MEM_TIMEOUT)) ? v : v + WAIT_W'(1);
    endfunction

    assign id_rs = hz.id_rs;
    assign id_rt = hz.id_rt;
    assign ex_rt = hz.ex_rt;

    // Hazard terms; register 0 is hardwired so a load into it never blocks ID
    assign mem_stall = hz.mem_req & ~hz.mem_ready;
    assign load_use  = hz.ex_memread & (ex_rt != '0) &
                       ((ex_rt == id_rs) | (hz.id_uses_rt & (ex_rt == id_rt)));

    // A wait cycle is one spent in MEM_WAIT still stalled and not halting
    assign wait_tick   = (state_q == ST_MEM_WAIT) & mem_stall & ~hz.wb_halt;
    assign timeout_hit = wait_tick & (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_en_c     = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_en_c    = 1'b0;
        memwb_flush_c = 1'b0;
        halted_c      = 1'b0;

        case (state_q)
            ST_HALTED: begin
                halted_c = 1'b1;
            end
            default: begin
                if (hz.wb_halt) begin
                    memwb_flush_c = 1'b1;
                    state_d       = ST_HALTED;
                end else if (mem_stall) begin
                    // Whole pipe frozen; a pending branch simply waits in EX
                    memwb_flush_c = 1'b1;
                    state_d       = ST_MEM_WAIT;
                end else begin
                    state_d    = ST_RUN;
                    pc_en_c    = 1'b1;
                    ifid_en_c  = 1'b1;
                    idex_en_c  = 1'b1;
                    exmem_en_c = 1'b1;
                    if (hz.branch_taken) begin
                        ifid_flush_c = 1'b1;
                        idex_flush_c = 1'b1;
                    end else if (load_use) begin
                        pc_en_c      = 1'b0;
                        ifid_en_c    = 1'b0;
                        idex_flush_c = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter only lives while stalled in MEM_WAIT; timeout flag is sticky
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q <= wait_tick ? sat_inc_wait(wait_cnt_q) : '0;
            if (timeout_hit) begin
                mem_timeout_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (!pc_en_c && (state_q != ST_HALTED)) begin
            stall_cnt_q <= sat_inc_cnt(stall_cnt_q);
        end
    end

    // Strobes are forced low the instant reset asserts, independent of clk
    assign hz.pc_en       = reset & pc_en_c;
    assign hz.ifid_en     = reset & ifid_en_c;
    assign hz.ifid_flush  = reset & ifid_flush_c;
    assign hz.idex_en     = reset & idex_en_c;
    assign hz.idex_flush  = reset & idex_flush_c;
    assign hz.exmem_en    = reset & exmem_en_c;
    assign hz.memwb_flush = reset & memwb_flush_c;
    assign hz.halted      = reset & halted_c;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a rule-level model is compared on
// every falling edge, and directed scenarios pin key values with literals.
module tb_pipe_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int MT    = 16;
    localparam int CNT_W = 16;

    logic clk;
    logic reset;

    pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(MT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model state: what the spec rules say about history
    bit m_halted  = 1'b0;
    bit m_waiting = 1'b0;
    int m_wait    = 0;
    bit m_tout    = 1'b0;
    int m_stalls  = 0;

    // Expected strobes {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl}
    function automatic logic [6:0] expect_strobes(
        input logic rst_n, input bit halted, input logic halt, input logic mreq,
        input logic mrdy, input logic br, input logic memrd,
        input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt, input logic use_rt);
        bit lu;
        lu = memrd && (xrt != 0) && ((xrt == rs) || (use_rt && (xrt == rt)));
        if (!rst_n || halted)   return 7'b000_0000;
        if (halt)               return 7'b000_0001;
        if (mreq && !mrdy)      return 7'b000_0001;
        if (br)                 return 7'b111_1110;
        if (lu)                 return 7'b000_1110;
        return 7'b110_1010;
    endfunction

    logic [6:0] exp_s;
    assign exp_s = expect_strobes(reset, m_halted, bus.wb_halt, bus.mem_req, bus.mem_ready,
                                  bus.branch_taken, bus.ex_memread, bus.ex_rt,
                                  bus.id_rs, bus.id_rt, bus.id_uses_rt);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_halted  <= 1'b0;
            m_waiting <= 1'b0;
            m_wait    <= 0;
            m_tout    <= 1'b0;
            m_stalls  <= 0;
        end else if (!m_halted) begin
            if (!exp_s[6]) m_stalls <= (m_stalls >= 65535) ? 65535 : m_stalls + 1;
            if (bus.wb_halt) begin
                m_halted  <= 1'b1;
                m_waiting <= 1'b0;
                m_wait    <= 0;
            end else if (bus.mem_req && !bus.mem_ready) begin
                if (m_waiting) begin
                    if (m_wait < MT) m_wait <= m_wait + 1;
                    if (m_wait + 1 == MT) m_tout <= 1'b1;
                end
                m_waiting <= 1'b1;
            end else begin
                m_waiting <= 1'b0;
                m_wait    <= 0;
            end
        end
    end

    always @(negedge clk) begin
        check("strobes",
              {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
               bus.idex_flush, bus.exmem_en, bus.memwb_flush}, exp_s);
        check("halted", bus.halted, (reset && m_halted) ? 1 : 0);
        check("mem_timeout", bus.mem_timeout, m_tout);
        check("stall_cnt", bus.stall_cnt, m_stalls);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_memread   = 1'b0;
        bus.ex_rt        = '0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b1;
        bus.wb_halt      = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        next(); next();
        #1;
        check("rst_pc_en", bus.pc_en, 0);
        check("rst_memwb", bus.memwb_flush, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_stall_cnt", bus.stall_cnt, 0);
        reset = 1'b1;

        // Free-running with no hazards
        for (int i = 0; i < 4; i++) begin
            next(); #1;
            check("norm_en", {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en}, 4'b1111);
        end
        check("norm_stall_cnt", bus.stall_cnt, 0);

        // Load-use on rs
        next();
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd5;
        #1;
        check("lu_pc_en", bus.pc_en, 0);
        check("lu_ifid_en", bus.ifid_en, 0);
        check("lu_idex_flush", bus.idex_flush, 1);
        next(); idle(); #1;
        check("lu_after_pc_en", bus.pc_en, 1);
        check("lu_stall_cnt", bus.stall_cnt, 1);

        // rt match without id_uses_rt, then with it, then ex_rt=0
        next();
        bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rs = 5'd3; bus.id_rt = 5'd5;
        #1;
        check("rt_unused_pc_en", bus.pc_en, 1);
        check("rt_unused_idex_fl", bus.idex_flush, 0);
        next(); bus.id_uses_rt = 1'b1; #1;
        check("rt_used_pc_en", bus.pc_en, 0);
        next(); idle();
        bus.ex_memread = 1'b1; bus.id_uses_rt = 1'b1;
        #1;
        check("rt_zero_pc_en", bus.pc_en, 1);
        next(); idle(); #1;
        check("rt_stall_cnt", bus.stall_cnt, 2);

        // Three wait cycles, then memory completes
        next(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next();
            #1;
            check("mw_memwb", bus.memwb_flush, 1);
            check("mw_pc_en", bus.pc_en, 0);
        end
        next(); bus.mem_ready = 1'b1; #1;
        check("mw_release_pc_en", bus.pc_en, 1);
        check("mw_release_memwb", bus.memwb_flush, 0);
        next(); idle(); #1;
        check("mw_stall_cnt", bus.stall_cnt, 5);
        check("mw_timeout", bus.mem_timeout, 0);

        // Branch held in EX while memory stalls
        next(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0; bus.branch_taken = 1'b1;
        #1;
        check("brs_ifid_fl", bus.ifid_flush, 0);
        next(); #1;
        check("brs_idex_fl", bus.idex_flush, 0);
        next(); bus.mem_ready = 1'b1; #1;
        check("brs_rel_flushes", {bus.ifid_flush, bus.idex_flush, bus.pc_en}, 3'b111);
        next(); idle(); #1;
        check("brs_stall_cnt", bus.stall_cnt, 7);

        // 16 stalled cycles: only 15 counted wait cycles, no timeout
        next(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        repeat (15) next();
        next(); bus.mem_ready = 1'b1; #1;
        check("to16_timeout", bus.mem_timeout, 0);
        next(); idle();

        // 20 stalled cycles: flag appears after the 16th MEM_WAIT cycle
        for (int i = 1; i <= 20; i++) begin
            next();
            if (i == 1) begin bus.mem_req = 1'b1; bus.mem_ready = 1'b0; end
            #1;
            if (i == 17) check("to20_before", bus.mem_timeout, 0);
            if (i == 18) check("to20_rise", bus.mem_timeout, 1);
        end
        next(); bus.mem_ready = 1'b1; #1;
        check("to_sticky_release", bus.mem_timeout, 1);
        next(); idle(); #1;
        check("to_sticky_idle", bus.mem_timeout, 1);
        check("to_stall_cnt", bus.stall_cnt, 43);

        // Reset asserted in the middle of MEM_WAIT
        next(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        next(); next();
        #2; reset = 1'b0; #1;
        check("mrst_pc_en", bus.pc_en, 0);
        check("mrst_memwb", bus.memwb_flush, 0);
        check("mrst_timeout", bus.mem_timeout, 0);
        check("mrst_stall_cnt", bus.stall_cnt, 0);
        next(); idle();
        next(); reset = 1'b1; #1;
        check("mrst_run_pc_en", bus.pc_en, 1);
        check("mrst_run_halted", bus.halted, 0);

        // Halt retires, then pipe stays frozen whatever arrives
        next(); bus.wb_halt = 1'b1; #1;
        check("halt_memwb", bus.memwb_flush, 1);
        check("halt_pc_en", bus.pc_en, 0);
        check("halt_not_yet", bus.halted, 0);
        next();
        bus.wb_halt = 1'b0; bus.branch_taken = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        #1;
        check("halted_flag", bus.halted, 1);
        check("halted_strobes",
              {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
               bus.idex_flush, bus.exmem_en, bus.memwb_flush}, 7'b0);
        repeat (4) next();
        idle(); #1;
        check("halted_hold", bus.halted, 1);
        check("halted_pc_en", bus.pc_en, 0);
        check("halted_stall_cnt", bus.stall_cnt, 1);

        next();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
